// File: rtl/audio_io_pkg.sv
// Shared constants and helpers for the audio I/O sigma-delta path.
// The LFSR constants are only used when AUDIO_SD_DITHER_EN is defined.
package audio_io_pkg;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Two's complement -> offset binary for a w-bit value held in the low bits.
  function automatic logic [15:0] to_offset_bin(input logic [15:0] s, input int unsigned w);
    return s ^ (16'h0001 << (w - 1));
  endfunction

endpackage

// File: rtl/sd_mod1.sv
// First-order sigma-delta modulator: W-bit accumulator whose carry-out is
// the registered 1-bit density output.
module sd_mod1 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena_i,
  input  logic [W-1:0] u_i,
  input  logic         cin_i,
  output logic         sd_o
);

  logic [W-1:0] acc_q, acc_d;
  logic         carry;
  logic         sd_q;

  always_comb begin
    {carry, acc_d} = {1'b0, acc_q} + {1'b0, u_i} + {{W{1'b0}}, cin_i};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sd_q  <= 1'b0;
    end else if (ena_i) begin
      acc_q <= acc_d;
      sd_q  <= carry;
    end
  end

  assign sd_o = sd_q;

endmodule

// File: rtl/audio_sd_dac_mc.sv
// Multi-channel first-order sigma-delta audio DAC with frame-synchronous
// sample transfer and sticky status. Define AUDIO_SD_DITHER_EN for LFSR dither.
module audio_sd_dac_mc
  import audio_io_pkg::*;
#(
  parameter  int N_CH     = 2,
  parameter  int W        = 12,
  parameter  int OSR_LOG2 = 6,
  localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [CHW-1:0]  s_chan,
  input  logic [W-1:0]    s_data,
  input  logic            clr_flags,
  output logic            frame_tick,
  output logic [N_CH-1:0] sd_out,
  output logic [N_CH-1:0] underrun,
  output logic [N_CH-1:0] overrun,
  output logic            err_chan
);

  logic [OSR_LOG2-1:0] cnt_q;
  logic [W-1:0]        shadow_q [N_CH];
  logic [W-1:0]        active_q [N_CH];
  logic [N_CH-1:0]     pending_q, pending_d;
  logic [N_CH-1:0]     under_q, under_d;
  logic [N_CH-1:0]     over_q, over_d;
  logic                err_q, err_d;
  logic                accept, chan_ok, wr_en, wrap, cin;

  assign s_ready = ena;
  assign accept  = s_valid & ena;
  assign chan_ok = int'(s_chan) < N_CH;
  assign wr_en   = accept & chan_ok;
  assign wrap    = ena & (&cnt_q);

  // NOTE: every combinational output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    pending_d = wrap ? '0 : pending_q;
    under_d   = clr_flags ? '0 : under_q;
    over_d    = clr_flags ? '0 : over_q;
    err_d     = clr_flags ? 1'b0 : err_q;
    if (wrap) under_d = under_d | ~pending_q;
    if (wr_en) begin
      if (pending_q[s_chan]) over_d[s_chan] = 1'b1;
      pending_d[s_chan] = 1'b1;
    end
    if (accept && !chan_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= '0;
      under_q   <= '0;
      over_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (ena) cnt_q <= cnt_q + 1'b1;
      pending_q <= pending_d;
      under_q   <= under_d;
      over_q    <= over_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the sample registers are reset on purpose: zero is midscale, so a
  // reset mid-stream must discard stale audio rather than replay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wrap) active_q[i] <= shadow_q[i];
        if (wr_en && (s_chan == CHW'(i))) shadow_q[i] <= s_data;
      end
    end
  end

`ifdef AUDIO_SD_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   lfsr_q <= LFSR_SEED;
    else if (ena) lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
  end

  assign cin = lfsr_q[0];
`else
  assign cin = 1'b0;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [W-1:0] u;
    assign u = W'(to_offset_bin(16'(active_q[g]), W));

    sd_mod1 #(.W(W)) u_mod (
      .clk   (clk),
      .rst_n (rst_n),
      .ena_i (ena),
      .u_i   (u),
      .cin_i (cin),
      .sd_o  (sd_out[g])
    );
  end

  assign frame_tick = wrap;
  assign underrun   = under_q;
  assign overrun    = over_q;
  assign err_chan   = err_q;

endmodule

// File: tb/tb_audio_sd_dac_mc.sv
// Self-checking bench for audio_sd_dac_mc: directed scenarios plus random
// traffic, compared every cycle against a behavioural frame/accumulator model.
module tb_audio_sd_dac_mc;

  localparam int N_CH = 2;
  localparam int W    = 12;
  localparam int OSR  = 64;
  localparam int FS   = 4096;
  localparam int HALF = 2048;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b0;
  logic            s_valid = 1'b0;
  logic [0:0]      s_chan = '0;
  logic [W-1:0]    s_data = '0;
  logic            clr_flags = 1'b0;
  logic            s_ready, frame_tick, err_chan;
  logic [N_CH-1:0] sd_out, underrun, overrun;

  logic            s_valid3 = 1'b0;
  logic [1:0]      s_chan3 = '0;
  logic [W-1:0]    s_data3 = '0;
  logic            clr3 = 1'b0;
  logic            s_ready3, frame_tick3, err_chan3;
  logic [2:0]      sd_out3, underrun3, overrun3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  audio_sd_dac_mc #(.N_CH(N_CH), .W(W), .OSR_LOG2(6)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s_valid(s_valid), .s_ready(s_ready),
    .s_chan(s_chan), .s_data(s_data), .clr_flags(clr_flags), .frame_tick(frame_tick),
    .sd_out(sd_out), .underrun(underrun), .overrun(overrun), .err_chan(err_chan)
  );

  audio_sd_dac_mc #(.N_CH(3), .W(W), .OSR_LOG2(6)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s_valid(s_valid3), .s_ready(s_ready3),
    .s_chan(s_chan3), .s_data(s_data3), .clr_flags(clr3), .frame_tick(frame_tick3),
    .sd_out(sd_out3), .underrun(underrun3), .overrun(overrun3), .err_chan(err_chan3)
  );

  // Reference model: sample values as signed integers, accumulators as
  // integers modulo 2^W, one ideal frame counter.
  int              m_cnt;
  int              m_shadow [N_CH];
  int              m_active [N_CH];
  int              m_acc    [N_CH];
  logic [N_CH-1:0] m_pend, m_sd, m_und, m_ovr;
  logic            m_err;
  int              m_lfsr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
      m_acc[i]    = 0;
    end
    m_pend = '0; m_sd = '0; m_und = '0; m_ovr = '0; m_err = 1'b0;
    m_lfsr = 'hACE1;
  endtask

  task automatic model_step(input bit v, input int ch, input int data, input bit clr, input bit en);
    logic [N_CH-1:0] old_pend;
    bit wrap;
    int cin;
    int s;
    if (!en) return;
    wrap     = (m_cnt == OSR - 1);
    old_pend = m_pend;
`ifdef AUDIO_SD_DITHER_EN
    cin = m_lfsr & 1;
`else
    cin = 0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      s        = m_acc[i] + (m_active[i] + HALF) + cin;
      m_sd[i]  = (s >= FS);
      m_acc[i] = s % FS;
    end
    if (clr) begin
      m_und = '0; m_ovr = '0; m_err = 1'b0;
    end
    if (wrap) begin
      m_und = m_und | ~old_pend;
      for (int i = 0; i < N_CH; i++) m_active[i] = m_shadow[i];
      m_pend = '0;
    end
    if (v) begin
      if (ch < N_CH) begin
        if (old_pend[ch]) m_ovr[ch] = 1'b1;
        m_shadow[ch] = data;
        m_pend[ch]   = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
    m_cnt  = (m_cnt + 1) % OSR;
  endtask

  // One clock: drive at the falling edge, check combinational outputs, then
  // advance the model at the rising edge and check registered outputs.
  task automatic cyc(input bit v, input int ch, input int data, input bit clr, input bit en);
    @(negedge clk);
    s_valid   = v;
    s_chan    = 1'(ch);
    s_data    = W'(data);
    clr_flags = clr;
    ena       = en;
    #1;
    check("s_ready", 32'(s_ready), 32'(en));
    check("frame_tick", 32'(frame_tick), 32'(en && (m_cnt == OSR - 1)));
    @(posedge clk);
    model_step(v, ch, data, clr, en);
    #1;
    check("sd_out", 32'(sd_out), 32'(m_sd));
    check("underrun", 32'(underrun), 32'(m_und));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("err_chan", 32'(err_chan), 32'(m_err));
  endtask

  task automatic idle_until_cnt(input int target);
    for (int k = 0; k < OSR && m_cnt != target; k++) cyc(0, 0, 0, 0, 1);
    check("align_cnt", 32'(m_cnt == target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sd_out"}, 32'(sd_out), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_err_chan"}, 32'(err_chan), 32'd0);
    check({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
  endtask

  initial begin
    int ones0, ones1;
    logic [N_CH-1:0] sd_hold;
    int v, ch, data, en, clr;

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;

    // Idle: midscale density and first-frame underrun
    ones0 = 0; ones1 = 0;
    for (int k = 0; k < FS; k++) begin
      cyc(0, 0, 0, 0, 1);
      ones0 += int'(sd_out[0]);
      ones1 += int'(sd_out[1]);
    end
`ifndef AUDIO_SD_DITHER_EN
    check("idle_ones_ch0", 32'(ones0), 32'd2048);
    check("idle_ones_ch1", 32'(ones1), 32'd2048);
`endif
    check("idle_underrun", 32'(underrun), 32'b11);

    // Full-scale positive on ch0, full-scale negative on ch1
    cyc(1, 0, 2047, 1, 1);
    cyc(1, 1, -2048, 0, 1);
    idle_until_cnt(0);
    check("fs_overrun", 32'(overrun), 32'd0);
    check("fs_underrun", 32'(underrun), 32'd0);
    ones0 = 0; ones1 = 0;
    for (int k = 0; k < FS; k++) begin
      cyc(0, 0, 0, 0, 1);
      ones0 += int'(sd_out[0]);
      ones1 += int'(sd_out[1]);
    end
`ifndef AUDIO_SD_DITHER_EN
    check("fs_ones_ch0", 32'(ones0), 32'd4095);
    check("fs_ones_ch1", 32'(ones1), 32'd0);
`endif

    // Double write in one frame -> overrun on ch1, then clear
    cyc(0, 0, 0, 1, 1);
    cyc(1, 1, 256, 0, 1);
    cyc(1, 1, 512, 0, 1);
    check("ovr_set", 32'(overrun), 32'b10);
    idle_until_cnt(0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    check("ovr_clr", 32'(overrun), 32'd0);
    check("und_clr", 32'(underrun), 32'd0);

    // Write landing on the exact wrap cycle
    idle_until_cnt(OSR - 1);
    cyc(1, 1, 1024, 0, 1);
    check("wrapwr_und", 32'(underrun), 32'b11);
    cyc(0, 0, 0, 1, 1);
    idle_until_cnt(0);
    check("wrapwr_next_und", 32'(underrun), 32'b01);

    // Enable low: everything frozen, writes refused
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1);
    sd_hold = sd_out;
    for (int k = 0; k < 10; k++) cyc(1, k % 2, -1, 0, 0);
    check("freeze_sd", 32'(sd_out), 32'(sd_hold));
    cyc(0, 0, 0, 0, 1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      v    = int'($urandom_range(0, 1));
      ch   = int'($urandom_range(0, 1));
      data = int'($urandom_range(0, FS - 1)) - HALF;
      en   = ($urandom_range(0, 7) != 0) ? 1 : 0;
      clr  = (en != 0 && $urandom_range(0, 31) == 0) ? 1 : 0;
      cyc(v[0], ch, data, clr[0], en[0]);
    end

    // Reset in the middle of a frame
    idle_until_cnt(20);
    @(negedge clk);
    ena   = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      v    = int'($urandom_range(0, 1));
      ch   = int'($urandom_range(0, 1));
      data = int'($urandom_range(0, FS - 1)) - HALF;
      cyc(v[0], ch, data, 1'b0, 1'b1);
    end

    // Three-channel instance: out-of-range channel index
    cyc(0, 0, 0, 0, 1);
    clr3 = 1'b1;
    cyc(0, 0, 0, 0, 1);
    clr3 = 1'b0;
    check("ch3_err_idle", 32'(err_chan3), 32'd0);
    s_valid3 = 1'b1; s_chan3 = 2'd3; s_data3 = 12'h123;
    cyc(0, 0, 0, 0, 1);
    s_chan3 = 2'd3; s_data3 = 12'h456;
    cyc(0, 0, 0, 0, 1);
    s_valid3 = 1'b0;
    check("ch3_err_set", 32'(err_chan3), 32'd1);
    check("ch3_no_ovr", 32'(overrun3), 32'd0);
    clr3 = 1'b1;
    cyc(0, 0, 0, 0, 1);
    clr3 = 1'b0;
    for (int k = 0; k < OSR + 1; k++) cyc(0, 0, 0, 0, 1);
    check("ch3_und_all", 32'(underrun3), 32'b111);
    check("ch3_err_clr", 32'(err_chan3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
